// File: rtl/phos_fec_pkg.sv
// rtl/phos_fec_pkg.sv - shared constants and types for the HV bias DAC loader
//  HV_N_CH      number of bias channels driven from the DTC register bank
//  HV_DAC_W     width of one DAC code
//  hv_frame_t   16-bit serial word {pad, addr[2:0], code[11:0]}, sent MSB first
//  hv_ldr_state_e  loader sequencer states
package phos_fec_pkg;

    localparam int HV_N_CH  = 32;
    localparam int HV_DAC_W = 12;

    typedef struct packed {
        logic                pad;
        logic [2:0]          addr;
        logic [HV_DAC_W-1:0] code;
    } hv_frame_t;

    typedef enum logic [2:0] {
        HV_IDLE,
        HV_LOAD,
        HV_CS_SETUP,
        HV_SHIFT,
        HV_CS_HOLD,
        HV_GAP,
        HV_LDAC,
        HV_DONE
    } hv_ldr_state_e;

endpackage

// File: rtl/spi_tx16.sv
// rtl/spi_tx16.sv - 16-bit MSB-first SPI shifter, CPOL=0, data changes on falling SCLK
//  clk_i       system clock
//  rst_i       async reset, active high
//  start_i     load frame_i and begin shifting (ignored while a frame is in flight)
//  frame_i     16-bit word to send
//  sclk_o      serial clock, idle low; each bit is CLK_DIV cycles low then CLK_DIV high
//  sdi_o       serial data, held low while idle
//  last_bit_o  high in the final cycle of the last SCLK high phase
module spi_tx16 #(
    parameter int CLK_DIV = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [15:0] frame_i,
    output logic        sclk_o,
    output logic        sdi_o,
    output logic        last_bit_o
);

    localparam int            DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);

    logic          active_q;
    logic          sclk_q;
    logic [DW-1:0] div_q;
    logic [3:0]    bit_q;
    logic [15:0]   shreg_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            active_q <= 1'b0;
            sclk_q   <= 1'b0;
            div_q    <= '0;
            bit_q    <= '0;
            shreg_q  <= '0;
        end else if (start_i && !active_q) begin
            active_q <= 1'b1;
            sclk_q   <= 1'b0;
            div_q    <= '0;
            bit_q    <= '0;
            shreg_q  <= frame_i;
        end else if (active_q) begin
            if (div_q == DIV_MAX) begin
                div_q <= '0;
                if (!sclk_q) begin
                    sclk_q <= 1'b1;
                end else begin
                    // Falling edge: advance to the next bit, or finish and park sdi low.
                    sclk_q <= 1'b0;
                    if (bit_q == 4'd15) begin
                        active_q <= 1'b0;
                        shreg_q  <= '0;
                    end else begin
                        bit_q   <= bit_q + 4'd1;
                        shreg_q <= {shreg_q[14:0], 1'b0};
                    end
                end
            end else begin
                div_q <= div_q + 1'b1;
            end
        end
    end

    assign sclk_o     = sclk_q;
    assign sdi_o      = shreg_q[15];
    assign last_bit_o = active_q && sclk_q && (div_q == DIV_MAX) && (bit_q == 4'd15);

endmodule

// File: rtl/hv_dac_loader.sv
// rtl/hv_dac_loader.sv - loads 32 APD bias codes into 4 octal DACs and strobes LDAC
//  dtc_clk      system clock
//  rst          async reset, active high
//  hv_update    1-cycle request to (re)load all channels
//  hv_dac_data  per-channel 12-bit codes, snapshotted at the start of a sequence
//  dac_sclk     serial clock, idle low
//  dac_sdi      serial data, MSB first
//  dac_cs_n     per-DAC chip select, active low, at most one low
//  dac_ldac_n   common load strobe, active low
//  busy         sequence in progress
//  done         1-cycle pulse as the LDAC pulse ends
module hv_dac_loader
    import phos_fec_pkg::*;
#(
    parameter int CLK_DIV    = 4,
    parameter int CH_PER_DAC = 8,
    parameter int N_DAC      = HV_N_CH / CH_PER_DAC,
    parameter int LDAC_W     = 4
) (
    input  logic                dtc_clk,
    input  logic                rst,
    input  logic                hv_update,
    input  logic [HV_DAC_W-1:0] hv_dac_data [N_DAC*CH_PER_DAC],
    output logic                dac_sclk,
    output logic                dac_sdi,
    output logic [N_DAC-1:0]    dac_cs_n,
    output logic                dac_ldac_n,
    output logic                busy,
    output logic                done
);

    localparam int N_CH    = N_DAC * CH_PER_DAC;
    localparam int CH_W    = $clog2(N_CH);
    localparam int AW      = $clog2(CH_PER_DAC);
    localparam int CNT_MAX = (CLK_DIV > LDAC_W) ? CLK_DIV : LDAC_W;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] LDAC_LAST = CNT_W'(LDAC_W - 1);
    localparam logic [CH_W-1:0]  CH_LAST   = CH_W'(N_CH - 1);

    hv_ldr_state_e       state_q;
    logic [CH_W-1:0]     ch_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                pending_q;
    logic [N_DAC-1:0]    cs_n_q;
    logic                ldac_n_q;
    logic                busy_q;
    logic                done_q;
    logic [HV_DAC_W-1:0] snap_q [N_CH];

    hv_frame_t frame;
    logic      spi_start;
    logic      spi_last;

    // Upper channel bits pick the DAC; only that one chip select goes low.
    function automatic logic [N_DAC-1:0] cs_for(input logic [CH_W-1:0] ch);
        return ~(N_DAC'(1) << (ch >> AW));
    endfunction

    always_comb begin
        frame      = '0;
        frame.addr = 3'(ch_q[AW-1:0]);
        frame.code = snap_q[ch_q];
    end

    // Hand the frame over on the last CS setup cycle so SHIFT starts with SCLK low.
    assign spi_start = (state_q == HV_CS_SETUP) && (cnt_q == DIV_LAST);

    // The running sequence works only from this copy, so host writes mid-sequence are harmless.
    always_ff @(posedge dtc_clk) begin
        if (state_q == HV_LOAD) begin
            snap_q <= hv_dac_data;
        end
    end

    always_ff @(posedge dtc_clk or posedge rst) begin
        if (rst) begin
            state_q   <= HV_IDLE;
            ch_q      <= '0;
            cnt_q     <= '0;
            pending_q <= 1'b0;
            cs_n_q    <= '1;
            ldac_n_q  <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            // Requests arriving mid-sequence coalesce into one re-run; DONE consumes them itself.
            if (hv_update && busy_q && (state_q != HV_DONE)) begin
                pending_q <= 1'b1;
            end
            case (state_q)
                HV_IDLE: begin
                    if (hv_update) begin
                        state_q <= HV_LOAD;
                        busy_q  <= 1'b1;
                    end
                end
                HV_LOAD: begin
                    ch_q    <= '0;
                    cnt_q   <= '0;
                    cs_n_q  <= cs_for('0);
                    state_q <= HV_CS_SETUP;
                end
                HV_CS_SETUP: begin
                    if (cnt_q == DIV_LAST) begin
                        cnt_q   <= '0;
                        state_q <= HV_SHIFT;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                HV_SHIFT: begin
                    if (spi_last) begin
                        state_q <= HV_CS_HOLD;
                    end
                end
                HV_CS_HOLD: begin
                    if (cnt_q == DIV_LAST) begin
                        cnt_q   <= '0;
                        cs_n_q  <= '1;
                        state_q <= HV_GAP;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                HV_GAP: begin
                    if (cnt_q == DIV_LAST) begin
                        cnt_q <= '0;
                        if (ch_q == CH_LAST) begin
                            ldac_n_q <= 1'b0;
                            state_q  <= HV_LDAC;
                        end else begin
                            ch_q    <= ch_q + 1'b1;
                            cs_n_q  <= cs_for(ch_q + 1'b1);
                            state_q <= HV_CS_SETUP;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                HV_LDAC: begin
                    if (cnt_q == LDAC_LAST) begin
                        cnt_q    <= '0;
                        ldac_n_q <= 1'b1;
                        done_q   <= 1'b1;
                        state_q  <= HV_DONE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                HV_DONE: begin
                    if (pending_q || hv_update) begin
                        pending_q <= 1'b0;
                        state_q   <= HV_LOAD;
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= HV_IDLE;
                    end
                end
                default: state_q <= HV_IDLE;
            endcase
        end
    end

    spi_tx16 #(
        .CLK_DIV (CLK_DIV)
    ) u_spi (
        .clk_i      (dtc_clk),
        .rst_i      (rst),
        .start_i    (spi_start),
        .frame_i    (frame),
        .sclk_o     (dac_sclk),
        .sdi_o      (dac_sdi),
        .last_bit_o (spi_last)
    );

    assign dac_cs_n   = cs_n_q;
    assign dac_ldac_n = ldac_n_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_hv_dac_loader.sv
// tb/tb_hv_dac_loader.sv - self-checking bench for hv_dac_loader
module tb_hv_dac_loader;
    import phos_fec_pkg::*;

    localparam int CLK_DIV    = 4;
    localparam int CH_PER_DAC = 8;
    localparam int N_DAC      = 4;
    localparam int LDAC_W     = 4;
    localparam int N_CH       = N_DAC * CH_PER_DAC;
    localparam int LAT        = 1 + N_CH * 35 * CLK_DIV + LDAC_W;
    localparam int LIMIT      = LAT + 2000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        hv_update = 1'b0;
    logic [11:0] data [N_CH];
    logic        dac_sclk, dac_sdi, dac_ldac_n, busy, done;
    logic [3:0]  dac_cs_n;

    int total = 0;
    int bad = 0;

    hv_dac_loader #(
        .CLK_DIV    (CLK_DIV),
        .CH_PER_DAC (CH_PER_DAC),
        .N_DAC      (N_DAC),
        .LDAC_W     (LDAC_W)
    ) dut (
        .dtc_clk     (clk),
        .rst         (rst),
        .hv_update   (hv_update),
        .hv_dac_data (data),
        .dac_sclk    (dac_sclk),
        .dac_sdi     (dac_sdi),
        .dac_cs_n    (dac_cs_n),
        .dac_ldac_n  (dac_ldac_n),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    // SPI slave + LDAC/done monitor, sampled on the falling system clock.
    logic [15:0] frames_val[$];
    int          frames_dac[$];
    int proto_err = 0, short_cnt = 0, ldac_pulses = 0, ldac_bad_w = 0;
    int done_cnt = 0, busy_rises = 0;
    int nb = 0, cur_dac = 0, hi_len = 0, ldac_len = 0;
    logic [15:0] sh = '0;
    logic        sclk_p = 1'b0, sdi_p = 1'b0, busy_p = 1'b0;
    logic [3:0]  cs_p = 4'hF;

    always @(negedge clk) begin
        if (rst) begin
            if (cs_p != 4'hF) short_cnt++;
            nb = 0; hi_len = 0; ldac_len = 0;
            sclk_p = 1'b0; sdi_p = 1'b0; cs_p = 4'hF; busy_p = 1'b0;
        end else begin
            if (dac_cs_n != 4'hF && $countones(~dac_cs_n) != 1) proto_err++;
            if (dac_sclk != sclk_p && dac_cs_n == 4'hF) proto_err++;
            if (!dac_ldac_n && dac_cs_n != 4'hF) proto_err++;
            if (dac_sdi != sdi_p && dac_sclk && sclk_p) proto_err++;
            if (dac_sclk) hi_len++;
            else if (hi_len != 0) begin
                if (hi_len != CLK_DIV) proto_err++;
                hi_len = 0;
            end
            if (dac_sclk && !sclk_p) begin
                sh = {sh[14:0], dac_sdi};
                nb++;
                for (int i = 0; i < N_DAC; i++) if (!dac_cs_n[i]) cur_dac = i;
            end
            if (cs_p != 4'hF && dac_cs_n == 4'hF) begin
                if (nb == 16) begin
                    frames_val.push_back(sh);
                    frames_dac.push_back(cur_dac);
                end else short_cnt++;
                nb = 0;
            end
            if (!dac_ldac_n) ldac_len++;
            else if (ldac_len != 0) begin
                ldac_pulses++;
                if (ldac_len != LDAC_W) ldac_bad_w++;
                ldac_len = 0;
            end
            if (done) done_cnt++;
            if (busy && !busy_p) busy_rises++;
            sclk_p = dac_sclk; sdi_p = dac_sdi; cs_p = dac_cs_n; busy_p = busy;
        end
    end

    // Reference: channel ch goes to DAC ch/8 as {0, ch%8, code}.
    function automatic logic [15:0] model_frame(int ch, logic [11:0] code);
        return {1'b0, 3'(ch % CH_PER_DAC), code};
    endfunction

    task automatic pulse_update();
        @(posedge clk); #1 hv_update = 1'b1;
        @(posedge clk); #1 hv_update = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!done && n < LIMIT) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic clear_frames();
        frames_val.delete();
        frames_dac.delete();
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        total++; if (dac_sclk !== 1'b0) begin bad++; $display("FAIL reset_sclk got=%b want=0", dac_sclk); end
        total++; if (dac_sdi !== 1'b0) begin bad++; $display("FAIL reset_sdi got=%b want=0", dac_sdi); end
        total++; if (dac_cs_n !== 4'hF) begin bad++; $display("FAIL reset_cs_n got=%h want=f", dac_cs_n); end
        total++; if (dac_ldac_n !== 1'b1) begin bad++; $display("FAIL reset_ldac_n got=%b want=1", dac_ldac_n); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
    endtask

    task automatic run_full(input string name, input logic [11:0] codes [N_CH]);
        int n, l0, d0;
        clear_frames();
        l0 = ldac_pulses; d0 = done_cnt;
        for (int i = 0; i < N_CH; i++) data[i] = codes[i];
        pulse_update();
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL %s_busy_start got=%b want=1", name, busy); end
        wait_done(n);
        total++; if (n !== LAT) begin bad++; $display("FAIL %s_latency got=%0d want=%0d", name, n, LAT); end
        repeat (3) @(posedge clk); #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL %s_busy_end got=%b want=0", name, busy); end
        total++; if (ldac_pulses - l0 !== 1 || ldac_bad_w !== 0) begin
            bad++; $display("FAIL %s_ldac pulses=%0d badw=%0d want 1/0", name, ldac_pulses - l0, ldac_bad_w);
        end
        total++; if (done_cnt - d0 !== 1) begin bad++; $display("FAIL %s_done_pulses got=%0d want=1", name, done_cnt - d0); end
        total++; if (frames_val.size() !== N_CH) begin bad++; $display("FAIL %s_nframes got=%0d want=%0d", name, frames_val.size(), N_CH); end
        for (int i = 0; i < N_CH && i < frames_val.size(); i++) begin
            total++;
            if (frames_val[i] !== model_frame(i, codes[i]) || frames_dac[i] !== i / CH_PER_DAC) begin
                bad++;
                $display("FAIL %s_frame[%0d] got dac%0d %h want dac%0d %h", name, i,
                         frames_dac[i], frames_val[i], i / CH_PER_DAC, model_frame(i, codes[i]));
            end
        end
        total++; if (proto_err !== 0) begin bad++; $display("FAIL %s_protocol got=%0d want=0", name, proto_err); end
    endtask

    task automatic test_ramp();
        logic [11:0] c [N_CH];
        for (int i = 0; i < N_CH; i++) c[i] = 12'h100 + 12'(i);
        run_full("ramp", c);
    endtask

    task automatic test_random();
        logic [11:0] c [N_CH];
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < N_CH; i++) c[i] = 12'($urandom);
            run_full("random", c);
        end
    endtask

    task automatic test_extremes();
        int n, b0;
        clear_frames();
        b0 = busy_rises;
        for (int i = 0; i < N_CH; i++) data[i] = 12'hFFF;
        pulse_update();
        wait_done(n);
        total++; if (n !== LAT) begin bad++; $display("FAIL ext_ff_latency got=%0d want=%0d", n, LAT); end
        total++; if (frames_val.size() !== N_CH) begin bad++; $display("FAIL ext_ff_nframes got=%0d want=%0d", frames_val.size(), N_CH); end
        for (int i = 0; i < N_CH && i < frames_val.size(); i++) begin
            total++;
            if (frames_val[i] !== model_frame(i, 12'hFFF)) begin
                bad++; $display("FAIL ext_ff_frame[%0d] got=%h want=%h", i, frames_val[i], model_frame(i, 12'hFFF));
            end
        end
        // Request lands in the DONE cycle: must re-run with the new data, busy held.
        clear_frames();
        for (int i = 0; i < N_CH; i++) data[i] = 12'h000;
        hv_update = 1'b1;
        @(posedge clk); #1 hv_update = 1'b0;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL ext_rerun_busy got=%b want=1", busy); end
        wait_done(n);
        total++; if (n !== LAT) begin bad++; $display("FAIL ext_00_latency got=%0d want=%0d", n, LAT); end
        total++; if (frames_val.size() !== N_CH) begin bad++; $display("FAIL ext_00_nframes got=%0d want=%0d", frames_val.size(), N_CH); end
        for (int i = 0; i < N_CH && i < frames_val.size(); i++) begin
            total++;
            if (frames_val[i] !== model_frame(i, 12'h000)) begin
                bad++; $display("FAIL ext_00_frame[%0d] got=%h want=%h", i, frames_val[i], model_frame(i, 12'h000));
            end
        end
        repeat (3) @(posedge clk); #1;
        total++; if (busy_rises - b0 !== 1) begin bad++; $display("FAIL ext_busy_rises got=%0d want=1", busy_rises - b0); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL ext_busy_end got=%b want=0", busy); end
    endtask

    task automatic test_snapshot();
        logic [11:0] c [N_CH];
        int n, g, d0;
        clear_frames();
        d0 = done_cnt;
        for (int i = 0; i < N_CH; i++) begin c[i] = 12'($urandom); data[i] = c[i]; end
        pulse_update();
        g = 0;
        while (frames_val.size() < 2 && g < 2000) begin @(posedge clk); #1; g++; end
        repeat (10) @(posedge clk);
        #1 data[5] = 12'hABC;
        wait_done(n);
        total++; if (n >= LIMIT) begin bad++; $display("FAIL snap_timeout waited=%0d want<%0d", n, LIMIT); end
        total++; if (frames_val.size() !== N_CH) begin bad++; $display("FAIL snap_nframes got=%0d want=%0d", frames_val.size(), N_CH); end
        for (int i = 0; i < N_CH && i < frames_val.size(); i++) begin
            total++;
            if (frames_val[i] !== model_frame(i, c[i])) begin
                bad++; $display("FAIL snap_frame[%0d] got=%h want=%h", i, frames_val[i], model_frame(i, c[i]));
            end
        end
        repeat (20) @(posedge clk); #1;
        total++; if (busy !== 1'b0 || done_cnt - d0 !== 1) begin
            bad++; $display("FAIL snap_no_rerun busy=%b dones=%0d want 0/1", busy, done_cnt - d0);
        end
    endtask

    task automatic test_back_to_back();
        logic [11:0] c [N_CH];
        int n, el, w, b0, d0, l0;
        clear_frames();
        b0 = busy_rises; d0 = done_cnt; l0 = ldac_pulses;
        for (int i = 0; i < N_CH; i++) begin c[i] = 12'($urandom); data[i] = c[i]; end
        pulse_update();
        el = 0;
        for (int k = 0; k < 3; k++) begin
            w = $urandom_range(50, 1400);
            repeat (w) @(posedge clk);
            #1 hv_update = 1'b1;
            @(posedge clk); #1 hv_update = 1'b0;
            el += w + 1;
        end
        wait_done(n);
        total++; if (n + el !== LAT) begin bad++; $display("FAIL b2b_first_latency got=%0d want=%0d", n + el, LAT); end
        @(posedge clk); #1;
        wait_done(n);
        total++; if (n !== LAT) begin bad++; $display("FAIL b2b_second_latency got=%0d want=%0d", n, LAT); end
        repeat (20) @(posedge clk); #1;
        total++; if (done_cnt - d0 !== 2) begin bad++; $display("FAIL b2b_done_pulses got=%0d want=2", done_cnt - d0); end
        total++; if (ldac_pulses - l0 !== 2) begin bad++; $display("FAIL b2b_ldac_pulses got=%0d want=2", ldac_pulses - l0); end
        total++; if (busy_rises - b0 !== 1) begin bad++; $display("FAIL b2b_busy_rises got=%0d want=1", busy_rises - b0); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL b2b_busy_end got=%b want=0", busy); end
        total++; if (frames_val.size() !== 2 * N_CH) begin bad++; $display("FAIL b2b_nframes got=%0d want=%0d", frames_val.size(), 2 * N_CH); end
        for (int i = 0; i < 2 * N_CH && i < frames_val.size(); i++) begin
            total++;
            if (frames_val[i] !== model_frame(i % N_CH, c[i % N_CH]) || frames_dac[i] !== (i % N_CH) / CH_PER_DAC) begin
                bad++; $display("FAIL b2b_frame[%0d] got=%h want=%h", i, frames_val[i], model_frame(i % N_CH, c[i % N_CH]));
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [11:0] c [N_CH];
        logic [3:0] want_cs;
        int g, l0, s0, d0;
        clear_frames();
        l0 = ldac_pulses; s0 = short_cnt; d0 = done_cnt;
        for (int i = 0; i < N_CH; i++) begin c[i] = 12'($urandom); data[i] = c[i]; end
        pulse_update();
        g = 0;
        while (frames_val.size() < 17 && g < 4000) begin @(posedge clk); #1; g++; end
        repeat ($urandom_range(20, 130)) @(posedge clk);
        #1;
        want_cs = ~(4'b0001 << (17 / CH_PER_DAC));
        total++; if (dac_cs_n !== want_cs) begin bad++; $display("FAIL rstmid_cs_before got=%h want=%h", dac_cs_n, want_cs); end
        rst = 1'b1;
        #1;
        total++; if (dac_cs_n !== 4'hF || dac_sclk !== 1'b0 || busy !== 1'b0 || dac_ldac_n !== 1'b1) begin
            bad++; $display("FAIL rstmid_outputs cs=%h sclk=%b busy=%b ldac_n=%b want f/0/0/1", dac_cs_n, dac_sclk, busy, dac_ldac_n);
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (10) @(posedge clk); #1;
        total++; if (ldac_pulses - l0 !== 0 || done_cnt - d0 !== 0) begin
            bad++; $display("FAIL rstmid_no_ldac ldac=%0d done=%0d want 0/0", ldac_pulses - l0, done_cnt - d0);
        end
        total++; if (short_cnt - s0 !== 1) begin bad++; $display("FAIL rstmid_partial got=%0d want=1", short_cnt - s0); end
        total++; if (frames_val.size() !== 17) begin bad++; $display("FAIL rstmid_nframes got=%0d want=17", frames_val.size()); end
        for (int i = 0; i < N_CH; i++) c[i] = 12'($urandom);
        run_full("after_rst", c);
    endtask

    initial begin
        for (int i = 0; i < N_CH; i++) data[i] = '0;
        test_reset();
        test_ramp();
        test_random();
        test_extremes();
        test_snapshot();
        test_back_to_back();
        test_reset_mid_frame();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
